// File: rtl/config_register_bank_if.sv
// BRAM-controller style port: word-aligned byte address, byte write enables,
// 32-bit write data in, registered 32-bit read data out.
interface config_register_bank_if;
   logic [31:0] addr;
   logic        en;
   logic [3:0]  wea;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output addr, en, wea, wdata, input rdata);
   modport slave  (input addr, en, wea, wdata, output rdata);
endinterface

// File: rtl/config_register_bank.sv
// Control / status / saturating event-counter bank behind a BRAM port.
// Optional macro CFG_SHADOW_EN: control words >= 1 are double-buffered and committed by ctrl0 bit 31.
module config_register_bank #(
   parameter int          NUM_CTRL     = 4,
   parameter int          NUM_STAT     = 2,
   parameter int          NUM_EVT      = 2,
   parameter logic [31:0] PULSE_MASK   = 32'h0000_0003,
   parameter logic [31:0] CTRL_RST_VAL = 32'h0
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i_n,
   input  logic                                     rst_i,
   config_register_bank_if.slave                    bus,
   output logic [32*NUM_CTRL-1:0]                   ctrl_o,
   output logic [31:0]                              pulse_o,
   input  logic [32*((NUM_STAT > 0) ? NUM_STAT : 1)-1:0] stat_i,
   input  logic [((NUM_EVT > 0) ? NUM_EVT : 1)-1:0]      evt_i
);

   localparam int          NE       = (NUM_EVT > 0) ? NUM_EVT : 1;
   localparam int unsigned EVT_BASE = NUM_CTRL + NUM_STAT;
`ifdef CFG_SHADOW_EN
   localparam logic [31:0] SELF_CLR = PULSE_MASK | 32'h8000_0000;
`else
   localparam logic [31:0] SELF_CLR = PULSE_MASK;
`endif

   logic [31:0] word_ext;
   logic        wr_en;
   logic [31:0] byte_mask;
   logic [31:0] ctrl_reg  [NUM_CTRL];
   logic [31:0] ctrl_next [NUM_CTRL];
   logic [31:0] cnt_val   [NE];
   logic [31:0] rd_next;
   logic [31:0] data_reg;
   logic        unused_addr_bits;

   assign word_ext  = {24'd0, bus.addr[9:2]};
   assign wr_en     = bus.en && (|bus.wea);
   assign byte_mask = {{8{bus.wea[3]}}, {8{bus.wea[2]}}, {8{bus.wea[1]}}, {8{bus.wea[0]}}};
   assign unused_addr_bits = ^{bus.addr[31:10], bus.addr[1:0]};

   // Self-clearing bits of word 0 drop every cycle unless rewritten, so
   // back-to-back writes give back-to-back pulses.
   always_comb begin
      for (int i = 0; i < NUM_CTRL; i++) begin
         ctrl_next[i] = ctrl_reg[i] & ((i == 0) ? ~SELF_CLR : 32'hFFFF_FFFF);
         if (wr_en && (word_ext == 32'(i)))
            ctrl_next[i] = (ctrl_next[i] & ~byte_mask) | (bus.wdata & byte_mask);
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NUM_CTRL; i++) begin
         if (!rst_i_n)
            ctrl_reg[i] <= (i == 0) ? (CTRL_RST_VAL & ~SELF_CLR) : CTRL_RST_VAL;
         else
            ctrl_reg[i] <= ctrl_next[i];
      end
   end

   assign pulse_o = ctrl_reg[0] & SELF_CLR;

`ifdef CFG_SHADOW_EN
   logic [31:0] active_reg [NUM_CTRL];

   // ctrl_reg holds the shadows; the live copy follows on the commit pulse.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NUM_CTRL; i++) begin
         if (!rst_i_n)
            active_reg[i] <= CTRL_RST_VAL;
         else if (ctrl_reg[0][31])
            active_reg[i] <= ctrl_reg[i];
      end
   end
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CTRL; gi++) begin : gen_ctrl_out
`ifdef CFG_SHADOW_EN
         if (gi == 0) begin : gen_direct
            assign ctrl_o[32*gi +: 32] = ctrl_reg[gi];
         end else begin : gen_shadowed
            assign ctrl_o[32*gi +: 32] = active_reg[gi];
         end
`else
         assign ctrl_o[32*gi +: 32] = ctrl_reg[gi];
`endif
      end

      for (gi = 0; gi < NUM_EVT; gi++) begin : gen_evt
         logic [31:0] cnt_reg;
         logic        hit;

         assign hit = wr_en && (word_ext == 32'(EVT_BASE + gi));

         always_ff @(posedge clk_i) begin
            if (!rst_i_n)
               cnt_reg <= 32'd0;
            else if (hit)
               cnt_reg <= {31'd0, evt_i[gi]};
            else if (evt_i[gi] && (cnt_reg != 32'hFFFF_FFFF))
               cnt_reg <= cnt_reg + 32'd1;
         end

         assign cnt_val[gi] = cnt_reg;
      end

      if (NUM_EVT == 0) begin : gen_no_evt
         logic unused_evt;
         assign unused_evt = ^evt_i;
         assign cnt_val[0] = 32'd0;
      end
   endgenerate

   // Read mux sees pre-edge state, giving read-before-write on write cycles.
   always_comb begin
      rd_next = 32'd0;
      for (int i = 0; i < NUM_CTRL; i++)
         if (word_ext == 32'(i)) rd_next = ctrl_reg[i];
      for (int i = 0; i < NUM_STAT; i++)
         if (word_ext == 32'(NUM_CTRL + i)) rd_next = stat_i[32*i +: 32];
      for (int i = 0; i < NUM_EVT; i++)
         if (word_ext == 32'(EVT_BASE + i)) rd_next = cnt_val[i];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i_n || rst_i)
         data_reg <= 32'd0;
      else if (bus.en)
         data_reg <= rd_next;
   end

   assign bus.rdata = data_reg;

endmodule
